// File: rtl/gate_response_checker_if.sv
// Bus between a 2-input gate stimulus bench (master) and gate_response_checker (slave).
// FIRST_FAIL_LOG_EN adds the first-mismatch log signals.
interface gate_response_checker_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic [2:0]       gate_sel;
   logic             in_valid;
   logic             a;
   logic             b;
   logic             c;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] chk_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic [3:0]       cov;
   logic             overrun;
`ifdef FIRST_FAIL_LOG_EN
   logic             ff_valid;
   logic [1:0]       ff_vec;
   logic [CNT_W-1:0] ff_idx;
   logic             ff_c;

   modport master (
      output start, gate_sel, in_valid, a, b, c,
      input  busy, done, pass, chk_cnt, fail_cnt, cov, overrun,
      input  ff_valid, ff_vec, ff_idx, ff_c
   );
   modport slave (
      input  start, gate_sel, in_valid, a, b, c,
      output busy, done, pass, chk_cnt, fail_cnt, cov, overrun,
      output ff_valid, ff_vec, ff_idx, ff_c
   );
`else
   modport master (
      output start, gate_sel, in_valid, a, b, c,
      input  busy, done, pass, chk_cnt, fail_cnt, cov, overrun
   );
   modport slave (
      input  start, gate_sel, in_valid, a, b, c,
      output busy, done, pass, chk_cnt, fail_cnt, cov, overrun
   );
`endif
endinterface

// File: rtl/gate_response_checker.sv
// Checks a 2-input gate DUT output against the selected golden function and reports a session verdict.
// Define FIRST_FAIL_LOG_EN to log the first mismatch of each session.
module gate_response_checker #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned NUM_VEC    = 4,
   parameter int unsigned SAMPLE_DLY = 1
) (
   input logic                    clk,
   input logic                    rst,
   gate_response_checker_if.slave bus
);
   localparam int unsigned      DLY_W     = 4;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W:0]   NUM_VEC_W = (CNT_W+1)'(NUM_VEC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state;
   logic [2:0]       sel_l;
   logic             a_l;
   logic             b_l;
   logic [DLY_W-1:0] dly;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [CNT_W-1:0] chk_r;
   logic [CNT_W-1:0] fail_r;
   logic [3:0]       cov_r;
   logic             ovr_r;
`ifdef FIRST_FAIL_LOG_EN
   logic             ffv_r;
   logic [1:0]       ffvec_r;
   logic [CNT_W-1:0] ffidx_r;
   logic             ffc_r;
`endif

   logic             expected_c;
   logic             mismatch_c;
   logic             last_c;
   logic [CNT_W:0]   chk_inc_c;
   logic [CNT_W-1:0] chk_next_c;
   logic [CNT_W-1:0] fail_next_c;
   logic [3:0]       cov_next_c;
   logic             ovr_next_c;

   // Illegal selects expect the inverse of c so every check fails.
   function automatic logic golden(input logic [2:0] sel, input logic x, input logic y,
                                   input logic z);
      logic r;
      case (sel)
         3'd0:    r = x & y;
         3'd1:    r = x | y;
         3'd2:    r = ~(x & y);
         3'd3:    r = ~(x | y);
         3'd4:    r = x ^ y;
         3'd5:    r = ~(x ^ y);
         default: r = ~z;
      endcase
      return r;
   endfunction

   // Next values for the compare edge; the session end uses the unsaturated count.
   always_comb begin
      expected_c  = golden(sel_l, a_l, b_l, bus.c);
      mismatch_c  = expected_c != bus.c;
      chk_inc_c   = {1'b0, chk_r} + (CNT_W+1)'(1);
      last_c      = chk_inc_c == NUM_VEC_W;
      chk_next_c  = (chk_r != CNT_MAX) ? chk_r + CNT_W'(1) : chk_r;
      fail_next_c = (mismatch_c && (fail_r != CNT_MAX)) ? fail_r + CNT_W'(1) : fail_r;
      cov_next_c  = cov_r | 4'(4'b0001 << {a_l, b_l});
      ovr_next_c  = ovr_r | bus.in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         sel_l   <= '0;
         a_l     <= 1'b0;
         b_l     <= 1'b0;
         dly     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         chk_r   <= '0;
         fail_r  <= '0;
         cov_r   <= '0;
         ovr_r   <= 1'b0;
`ifdef FIRST_FAIL_LOG_EN
         ffv_r   <= 1'b0;
         ffvec_r <= '0;
         ffidx_r <= '0;
         ffc_r   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state   <= S_ARMED;
                  sel_l   <= bus.gate_sel;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  pass_r  <= 1'b0;
                  chk_r   <= '0;
                  fail_r  <= '0;
                  cov_r   <= '0;
                  ovr_r   <= 1'b0;
`ifdef FIRST_FAIL_LOG_EN
                  ffv_r   <= 1'b0;
                  ffvec_r <= '0;
                  ffidx_r <= '0;
                  ffc_r   <= 1'b0;
`endif
               end
            end
            S_ARMED: begin
               if (bus.in_valid) begin
                  state <= S_WAIT;
                  a_l   <= bus.a;
                  b_l   <= bus.b;
                  dly   <= DLY_W'(SAMPLE_DLY);
               end
            end
            S_WAIT: begin
               ovr_r <= ovr_next_c;
               if (dly != '0) begin
                  dly <= dly - DLY_W'(1);
               end else begin
                  chk_r  <= chk_next_c;
                  fail_r <= fail_next_c;
                  cov_r  <= cov_next_c;
`ifdef FIRST_FAIL_LOG_EN
                  if (mismatch_c && !ffv_r) begin
                     ffv_r   <= 1'b1;
                     ffvec_r <= {a_l, b_l};
                     ffidx_r <= chk_r;
                     ffc_r   <= bus.c;
                  end
`endif
                  if (last_c) begin
                     state  <= S_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     pass_r <= (fail_next_c == '0) && (cov_next_c == 4'hF) && !ovr_next_c;
                  end else begin
                     state <= S_ARMED;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.pass     = pass_r;
   assign bus.chk_cnt  = chk_r;
   assign bus.fail_cnt = fail_r;
   assign bus.cov      = cov_r;
   assign bus.overrun  = ovr_r;
`ifdef FIRST_FAIL_LOG_EN
   assign bus.ff_valid = ffv_r;
   assign bus.ff_vec   = ffvec_r;
   assign bus.ff_idx   = ffidx_r;
   assign bus.ff_c     = ffc_r;
`endif

endmodule
